// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown controller and its count register.
package countdown_pkg;

   localparam int WIDTH_DEF = 4;
   localparam logic [WIDTH_DEF-1:0] ZERO_COUNT = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == RUN) || (s == PAUSE);
   endfunction

endpackage

// File: rtl/countdown_ctrl_count_reg.sv
// WIDTH-bit count register with asynchronous active-high clear.
module count_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: owns the next-count mux and FSM for the count register.
// Optional macro COUNTDOWN_CTRL_AUTO_RELOAD_EN makes DONE reload the start value and rerun.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc,
   output state_t           state_dbg
);

   localparam logic [WIDTH-1:0] ZERO = WIDTH'(ZERO_COUNT);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // start is a single-cycle request with no ready: it is acted on only when the
   // FSM is IDLE and abort is low, otherwise it is dropped (never queued).
   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  reload_q <= '0;
      else if (state == IDLE && start && !abort)  reload_q <= load_val;
   end
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (abort) begin
               count_nxt = ZERO;
            end else if (start) begin
               count_nxt = load_val;
               state_nxt = (load_val == ZERO) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               count_nxt = ZERO;
               state_nxt = IDLE;
            end else if (pause) begin
               state_nxt = PAUSE;
            end else if (count == ONE) begin
               count_nxt = ZERO;
               state_nxt = DONE;
            end else begin
               count_nxt = count - ONE;
            end
         end
         PAUSE: begin
            // Leaving PAUSE costs one edge with the count held.
            if (abort) begin
               count_nxt = ZERO;
               state_nxt = IDLE;
            end else if (!pause) begin
               state_nxt = RUN;
            end
         end
         DONE: begin
            count_nxt = ZERO;
            if (abort) begin
               state_nxt = IDLE;
            end else begin
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
               if (reload_q != ZERO) begin
                  count_nxt = reload_q;
                  state_nxt = RUN;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: begin
            count_nxt = ZERO;
            state_nxt = IDLE;
         end
      endcase
   end

   count_reg #(
      .WIDTH (WIDTH)
   ) u_count_reg (
      .clk   (clk),
      .reset (reset),
      .d     (count_nxt),
      .q     (count)
   );

   assign busy      = is_busy(state);
   assign done      = (state == DONE);
   assign tc        = (count == ZERO);
   assign state_dbg = state;

endmodule
